dcache_wb: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache between the MA stage data-memory port and the block-wide main data memory.
- Presents the same READ/WRITE/BUSYWAIT byte-addressed interface the MA stage already drives.
- Stalls the pipeline through BUSYWAIT only on misses.
- 16-byte blocks; the main-memory side moves whole 128-bit blocks.

---
 rtl/dcache_wb.sv | 156 +++++++++++++++
 tb/tb_dcache_wb.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_wb.sv
// Direct-mapped write-back, write-allocate data cache between the MA stage and
// block-wide main memory. 16-byte lines; hits never stall, misses fill whole lines.
module dcache_wb #(
   parameter int NUM_SETS   = 8,
   parameter int MEM_ADDR_W = 28
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [3:0]            READ,
   input  logic [2:0]            WRITE,
   input  logic [31:0]           ADDRESS,
   input  logic [31:0]           WRITEDATA,
   output logic [31:0]           READDATA,
   output logic                  BUSYWAIT,
   output logic                  MEM_READ,
   output logic                  MEM_WRITE,
   output logic [MEM_ADDR_W-1:0] MEM_ADDRESS,
   output logic [127:0]          MEM_WRITEDATA,
   input  logic [127:0]          MEM_READDATA,
   input  logic                  MEM_BUSYWAIT
);

   localparam int IDX_W = $clog2(NUM_SETS);
   localparam int TAG_W = 28 - IDX_W;

   typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;

   state_t               state, state_nxt;
   logic [NUM_SETS-1:0]  valid, dirty;
   logic [TAG_W-1:0]     tag_mem  [NUM_SETS];
   logic [127:0]         data_mem [NUM_SETS];

   logic [IDX_W-1:0]     idx;
   logic [TAG_W-1:0]     tag;
   logic [3:0]           off;
   logic [127:0]         line;
   logic                 rd_en, wr_en, req, hit, fill, commit_wr;
   logic [15:0]          wr_be;
   logic [127:0]         wr_line, merged;
   logic [7:0]           rd_byte;
   logic [15:0]          rd_half;

   assign off   = ADDRESS[3:0];
   assign idx   = ADDRESS[IDX_W+3:4];
   assign tag   = ADDRESS[31:IDX_W+4];
   assign line  = data_mem[idx];
   assign rd_en = READ[3];
   assign wr_en = WRITE[2] & ~READ[3];
   assign req   = READ[3] | WRITE[2];
   assign hit   = valid[idx] && (tag_mem[idx] == tag);

   // READDATA is forced to zero whenever there is no load hit, which also covers reset
   always_comb begin
      READDATA = '0;
      rd_byte  = line[{off, 3'b000} +: 8];
      rd_half  = line[{off[3:1], 4'b0000} +: 16];
      if (RST && rd_en && hit) begin
         case (READ[2:0])
            3'b000:  READDATA = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  READDATA = {{16{rd_half[15]}}, rd_half};
            3'b010:  READDATA = line[{off[3:2], 5'b00000} +: 32];
            3'b100:  READDATA = {24'h0, rd_byte};
            3'b101:  READDATA = {16'h0, rd_half};
            default: READDATA = '0;
         endcase
      end
   end

   always_comb begin
      wr_be   = '0;
      wr_line = '0;
      case (WRITE[1:0])
         2'b00: begin
            wr_be[off]                     = 1'b1;
            wr_line[{off, 3'b000} +: 8]    = WRITEDATA[7:0];
         end
         2'b01: begin
            wr_be[{off[3:1], 1'b0} +: 2]         = '1;
            wr_line[{off[3:1], 4'b0000} +: 16]   = WRITEDATA[15:0];
         end
         2'b10: begin
            wr_be[{off[3:2], 2'b00} +: 4]        = '1;
            wr_line[{off[3:2], 5'b00000} +: 32]  = WRITEDATA;
         end
         default: ;
      endcase
      merged = line;
      for (int unsigned i = 0; i < 16; i++)
         if (wr_be[i]) merged[i*8 +: 8] = wr_line[i*8 +: 8];
   end

   assign fill      = (state == FETCH) && !MEM_BUSYWAIT;
   assign commit_wr = wr_en && (((state == IDLE) && hit) || (state == UPDATE));

   always_comb begin
      state_nxt     = state;
      BUSYWAIT      = 1'b0;
      MEM_READ      = 1'b0;
      MEM_WRITE     = 1'b0;
      MEM_ADDRESS   = '0;
      MEM_WRITEDATA = '0;
      case (state)
         IDLE: begin
            BUSYWAIT = req && !hit;
            if (req && !hit)
               state_nxt = (valid[idx] && dirty[idx]) ? WRITEBACK : FETCH;
         end
         WRITEBACK: begin
            BUSYWAIT      = 1'b1;
            MEM_WRITE     = 1'b1;
            MEM_ADDRESS   = MEM_ADDR_W'({tag_mem[idx], idx});
            MEM_WRITEDATA = line;
            if (!MEM_BUSYWAIT) state_nxt = FETCH;
         end
         FETCH: begin
            BUSYWAIT    = 1'b1;
            MEM_READ    = 1'b1;
            MEM_ADDRESS = MEM_ADDR_W'(ADDRESS[31:4]);
            if (!MEM_BUSYWAIT) state_nxt = UPDATE;
         end
         UPDATE: begin
            BUSYWAIT  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // the IDLE miss term is live on inputs, so hold the stall low during reset
      BUSYWAIT = BUSYWAIT & RST;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= IDLE;
         valid <= '0;
         dirty <= '0;
      end else begin
         state <= state_nxt;
         if (fill) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
         end else if (commit_wr) begin
            dirty[idx] <= 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (fill) begin
         data_mem[idx] <= MEM_READDATA;
         tag_mem[idx]  <= tag;
      end else if (commit_wr) begin
         data_mem[idx] <= merged;
      end
   end

endmodule

// File: tb/tb_dcache_wb.sv
// Bench for dcache_wb: line-level cache/memory model predicts a per-cycle output
// timeline for each request; one negedge process compares the DUT against it.
module tb_dcache_wb;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [3:0]   rd_f = '0;
   logic [2:0]   wr_f = '0;
   logic [31:0]  addr = '0;
   logic [31:0]  wdata = '0;
   logic [31:0]  readdata;
   logic         busywait, mem_read, mem_write, mem_busywait;
   logic [27:0]  mem_address;
   logic [127:0] mem_writedata, mem_readdata;

   dcache_wb #(.NUM_SETS(8), .MEM_ADDR_W(28)) dut (
      .CLK(clk), .RST(rst), .READ(rd_f), .WRITE(wr_f), .ADDRESS(addr),
      .WRITEDATA(wdata), .READDATA(readdata), .BUSYWAIT(busywait),
      .MEM_READ(mem_read), .MEM_WRITE(mem_write), .MEM_ADDRESS(mem_address),
      .MEM_WRITEDATA(mem_writedata), .MEM_READDATA(mem_readdata),
      .MEM_BUSYWAIT(mem_busywait)
   );

   always #5 clk = ~clk;

   // main memory: busy for tm cycles of each request, then completes
   logic [127:0] env_mem [64];
   int tm = 0;
   int cnt = 0;
   assign mem_busywait = (mem_read | mem_write) && (cnt < tm);
   assign mem_readdata = env_mem[mem_address[5:0]];
   always @(posedge clk) begin
      if (!(mem_read | mem_write) || !mem_busywait) cnt <= 0;
      else cnt <= cnt + 1;
      if (mem_write && !mem_busywait) env_mem[mem_address[5:0]] <= mem_writedata;
   end

   // reference model
   logic         m_valid [8];
   logic         m_dirty [8];
   logic [24:0]  m_tag   [8];
   logic [127:0] m_data  [8];
   logic [127:0] model_mem [64];

   typedef struct {
      logic         bw, mr, mw;
      logic         chk_addr;
      logic [27:0]  maddr;
      logic         chk_wd;
      logic [127:0] wd;
      logic         chk_rd;
      logic [31:0]  rd;
   } exp_t;
   exp_t exp_q[$];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check("busywait", busywait, e.bw);
         check("mem_read", mem_read, e.mr);
         check("mem_write", mem_write, e.mw);
         if (e.chk_addr) check("mem_address", mem_address, e.maddr);
         if (e.chk_wd) check("mem_writedata", mem_writedata, e.wd);
         if (e.chk_rd) check("readdata", readdata, e.rd);
      end
   end

   function automatic logic [31:0] load_val(input logic [127:0] blk, input int off, input logic [2:0] f3);
      logic [31:0] v;
      case (f3)
         3'b000: begin v = 32'(blk[off*8 +: 8]); if (v >= 128) v = v | 32'hFFFFFF00; end
         3'b001: begin v = 32'(blk[(off/2)*16 +: 16]); if (v >= 32768) v = v | 32'hFFFF0000; end
         3'b010: v = blk[(off/4)*32 +: 32];
         3'b100: v = 32'(blk[off*8 +: 8]);
         3'b101: v = 32'(blk[(off/2)*16 +: 16]);
         default: v = 0;
      endcase
      return v;
   endfunction

   function automatic logic [127:0] store_merge(input logic [127:0] blk, input int off,
                                                input logic [1:0] sz, input logic [31:0] d);
      logic [127:0] b;
      b = blk;
      case (sz)
         2'b00: b[off*8 +: 8] = d[7:0];
         2'b01: b[(off/2)*16 +: 16] = d[15:0];
         2'b10: b[(off/4)*32 +: 32] = d;
         default: ;
      endcase
      return b;
   endfunction

   function automatic exp_t mk(input logic bw, input logic mr, input logic mw);
      exp_t e;
      e.bw = bw; e.mr = mr; e.mw = mw;
      e.chk_addr = 1'b0; e.maddr = '0;
      e.chk_wd = 1'b0; e.wd = '0;
      e.chk_rd = 1'b0; e.rd = '0;
      return e;
   endfunction

   logic [31:0]  last_rd;
   logic         c1_mr, c1_mw;
   logic [27:0]  c1_addr;
   logic [127:0] c1_wd;

   task automatic do_op(input logic [3:0] r, input logic [2:0] w, input logic [31:0] a,
                        input logic [31:0] d, input int t);
      int unsigned i;
      int n;
      logic [24:0] tg;
      exp_t e;
      #1;
      rd_f = r; wr_f = w; addr = a; wdata = d; tm = t;
      i  = a[6:4];
      tg = a[31:7];
      n  = 0;
      if ((r[3] | w[2]) && !(m_valid[i] && m_tag[i] == tg)) begin
         exp_q.push_back(mk(1'b1, 1'b0, 1'b0)); n++;
         if (m_valid[i] && m_dirty[i]) begin
            for (int k = 0; k <= t; k++) begin
               e = mk(1'b1, 1'b0, 1'b1);
               e.chk_addr = 1'b1; e.maddr = {m_tag[i], 3'(i)};
               e.chk_wd = 1'b1; e.wd = m_data[i];
               exp_q.push_back(e); n++;
            end
            model_mem[{m_tag[i][2:0], 3'(i)}] = m_data[i];
         end
         for (int k = 0; k <= t; k++) begin
            e = mk(1'b1, 1'b1, 1'b0);
            e.chk_addr = 1'b1; e.maddr = a[31:4];
            exp_q.push_back(e); n++;
         end
         m_data[i] = model_mem[a[9:4]];
         m_valid[i] = 1'b1; m_dirty[i] = 1'b0; m_tag[i] = tg;
         exp_q.push_back(mk(1'b1, 1'b0, 1'b0)); n++;
      end
      e = mk(1'b0, 1'b0, 1'b0);
      e.chk_rd = r[3];
      e.rd = load_val(m_data[i], int'(a[3:0]), r[2:0]);
      exp_q.push_back(e); n++;
      if (w[2] && !r[3]) begin
         m_data[i] = store_merge(m_data[i], int'(a[3:0]), w[1:0], d);
         m_dirty[i] = 1'b1;
      end
      @(negedge clk);
      last_rd = readdata;
      for (int k = 1; k < n; k++) begin
         @(negedge clk);
         if (k == 1) begin
            c1_mr = mem_read; c1_mw = mem_write; c1_addr = mem_address; c1_wd = mem_writedata;
         end
         last_rd = readdata;
      end
      @(posedge clk);
   endtask

   task automatic model_reset();
      for (int k = 0; k < 8; k++) begin
         m_valid[k] = 1'b0; m_dirty[k] = 1'b0;
      end
   endtask

   localparam logic [3:0] LB = 4'b1000, LH = 4'b1001, LW = 4'b1010, LBU = 4'b1100, LHU = 4'b1101;
   localparam logic [2:0] SB = 3'b100, SH = 3'b101, SW = 3'b110;

   initial begin
      for (int k = 0; k < 64; k++) begin
         env_mem[k] = {$urandom, $urandom, $urandom, $urandom};
         model_mem[k] = env_mem[k];
      end
      env_mem[4] = 128'hDDDD80CC_BBBBAAAA_55667788_11223344;
      model_mem[4] = env_mem[4];
      for (int k = 0; k < 8; k++) begin
         m_tag[k] = '0; m_data[k] = '0;
      end
      model_reset();

      #2 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_busywait", busywait, 1'b0);
      check("reset_mem_read", mem_read, 1'b0);
      check("reset_mem_write", mem_write, 1'b0);
      check("reset_readdata", readdata, 32'h0);
      check("reset_mem_address", mem_address, 28'h0);
      rst = 1'b1;
      @(posedge clk);

      do_op(LW, 3'b000, 32'h40, 32'h0, 3);
      check("lw40_fetch_mem_read", c1_mr, 1'b1);
      check("lw40_fetch_addr", c1_addr, 28'h4);
      check("lw40_readdata", last_rd, 32'h11223344);
      do_op(LW, 3'b000, 32'h40, 32'h0, 0);
      check("lw40_hit", last_rd, 32'h11223344);
      do_op(LB, 3'b000, 32'h43, 32'h0, 0);
      check("lb43", last_rd, 32'h00000011);
      do_op(LBU, 3'b000, 32'h43, 32'h0, 0);
      check("lbu43", last_rd, 32'h00000011);
      do_op(LB, 3'b000, 32'h4C, 32'h0, 0);
      check("lb4c", last_rd, 32'hFFFFFFCC);
      do_op(LBU, 3'b000, 32'h4C, 32'h0, 0);
      check("lbu4c", last_rd, 32'h000000CC);

      do_op(4'b0000, SW, 32'h40, 32'hCAFEBABE, 0);
      do_op(LW, 3'b000, 32'hC0, 32'h0, 1);
      check("wb_mem_write", c1_mw, 1'b1);
      check("wb_addr", c1_addr, 28'h4);
      check("wb_data_word0", c1_wd[31:0], 32'hCAFEBABE);

      do_op(4'b0000, SW, 32'h100, 32'h12345678, 2);
      do_op(LW, 3'b000, 32'h100, 32'h0, 0);
      check("lw100", last_rd, 32'h12345678);
      do_op(4'b0000, SH, 32'h102, 32'h0000BEEF, 0);
      do_op(LW, 3'b000, 32'h100, 32'h0, 0);
      check("lw100_after_sh", last_rd, 32'hBEEF5678);

      // reset asserted while a fetch is outstanding
      #1;
      rd_f = LW; wr_f = 3'b000; addr = 32'h2A0; tm = 5;
      @(negedge clk);
      @(negedge clk);
      check("midfetch_mem_read", mem_read, 1'b1);
      #2 rst = 1'b0;
      #1;
      check("midfetch_rst_mem_read", mem_read, 1'b0);
      check("midfetch_rst_busywait", busywait, 1'b0);
      model_reset();
      rd_f = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      do_op(LW, 3'b000, 32'h2A0, 32'h0, 1);
      check("refetch_mem_read", c1_mr, 1'b1);
      check("refetch_addr", c1_addr, 28'h2A);

      // back-to-back hits
      do_op(LW, 3'b000, 32'h2A0, 32'h0, 0);
      do_op(4'b0000, SW, 32'h2A4, 32'h8001F00D, 0);
      do_op(LW, 3'b000, 32'h2A4, 32'h0, 0);
      do_op(LH, 3'b000, 32'h2A6, 32'h0, 0);
      check("b2b_lh_sign", last_rd, 32'hFFFF8001);

      for (int k = 0; k < 400; k++) begin
         int sel;
         logic [3:0] r;
         logic [2:0] w;
         sel = $urandom_range(0, 9);
         r = '0; w = '0;
         case (sel)
            1: r = LB;  2: r = LH;  3: r = LW;  4: r = LBU;  5: r = LHU;
            6: w = SB;  7: w = SH;  8: w = SW;
            default: ;
         endcase
         do_op(r, w, $urandom_range(0, 1023), $urandom, $urandom_range(0, 3));
      end

      #1;
      rd_f = '0; wr_f = '0;
      repeat (2) @(posedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
